// File: rtl/id_operand_fetch_pkg.sv
// Shared constants for the decode/operand-fetch stage: MIPS field positions,
// opcode/funct encodings and the destination-register decode.
package id_operand_fetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [2:0] OP_STORE   = 3'b101;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  localparam logic [4:0] REG_RA     = 5'd31;

  // Register written by the instruction; 0 means no architectural write.
  function automatic logic [4:0] dest_of(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] d;
    op    = inst[OP_MSB:OP_LSB];
    funct = inst[FUNCT_MSB:FUNCT_LSB];
    d     = inst[RT_MSB:RT_LSB];
    case (op)
      OP_SPECIAL: d = (funct == FUNCT_JR) ? 5'd0 : inst[RD_MSB:RD_LSB];
      OP_JAL:     d = REG_RA;
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: d = 5'd0;
      default:    if (op[5:3] == OP_STORE) d = 5'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_operand_fetch_scoreboard.sv
// Per-register busy bits: one in-flight writer per GPR. Query results already
// discount a same-cycle writeback so a dependent inst can issue on that cycle.
module reg_scoreboard #(
  parameter int ADDR_WIDTH = id_operand_fetch_pkg::ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_set,
  input  logic [ADDR_WIDTH-1:0]     i_set_idx,
  input  logic                      i_clr,
  input  logic [ADDR_WIDTH-1:0]     i_clr_idx,
  input  logic                      i_fclr,
  input  logic [ADDR_WIDTH-1:0]     i_fclr_idx,
  input  logic [2:0][ADDR_WIDTH-1:0] i_q_idx,
  output logic [2:0]                o_q_busy,
  output logic [(1<<ADDR_WIDTH)-1:0] o_busy
);
  localparam int NR = 1 << ADDR_WIDTH;

  logic [NR-1:0] r_busy;
  logic [NR-1:0] w_set_mask;
  logic [NR-1:0] w_clr_mask;
  logic [NR-1:0] w_fclr_mask;
  logic [NR-1:0] w_busy_eff;
  logic [NR-1:0] w_busy_nxt;

  always_comb begin
    w_set_mask  = i_set  ? (NR'(1) << i_set_idx)  : '0;
    w_clr_mask  = i_clr  ? (NR'(1) << i_clr_idx)  : '0;
    w_fclr_mask = i_fclr ? (NR'(1) << i_fclr_idx) : '0;
    w_busy_eff    = r_busy & ~w_clr_mask;
    w_busy_eff[0] = 1'b0;
    // Set is applied last so a same-cycle set and clear of one index leaves it busy.
    w_busy_nxt    = (r_busy & ~w_clr_mask & ~w_fclr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  for (genvar q = 0; q < 3; q++) begin : g_query
    assign o_q_busy[q] = w_busy_eff[i_q_idx[q]];
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/id_operand_fetch.sv
// Decode/operand-fetch stage: register read with writeback bypass, scoreboard
// hazard stall and a one-entry valid/ready output register toward EX.
module id_operand_fetch #(
  parameter int DATA_WIDTH = id_operand_fetch_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = id_operand_fetch_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [DATA_WIDTH-1:0] inst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_inst,
  output logic [DATA_WIDTH-1:0] ex_op1,
  output logic [DATA_WIDTH-1:0] ex_op2,
  output logic [ADDR_WIDTH-1:0] ex_dst
);
  import id_operand_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0] w_rs, w_rt, w_dst;
  logic [DATA_WIDTH-1:0] w_op1, w_op2;
  logic                  w_wb_live, w_hazard, w_fire, w_flush_drop;
  logic [2:0]            w_q_busy;
  logic [(1<<ADDR_WIDTH)-1:0] w_busy;

  logic                  r_ex_valid;
  logic [DATA_WIDTH-1:0] r_ex_pc, r_ex_inst, r_ex_op1, r_ex_op2;
  logic [ADDR_WIDTH-1:0] r_ex_dst;

  assign w_rs  = inst[RS_MSB:RS_LSB];
  assign w_rt  = inst[RT_MSB:RT_LSB];
  assign w_dst = dest_of(inst[31:0]);

  assign rf_raddr1 = w_rs;
  assign rf_raddr2 = w_rt;

  assign w_wb_live = wb_wen && (wb_waddr != '0);
  assign w_op1     = (w_wb_live && wb_waddr == w_rs) ? wb_wdata : rf_rdata1;
  assign w_op2     = (w_wb_live && wb_waddr == w_rt) ? wb_wdata : rf_rdata2;

  assign w_hazard     = |w_q_busy;
  assign inst_ready   = !flush && !w_hazard && (!r_ex_valid || ex_ready);
  assign w_fire       = inst_valid && inst_ready;
  // A held inst dropped by flush never reached EX, so its dst reservation is released.
  assign w_flush_drop = flush && r_ex_valid && !ex_ready;

  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_fire && (w_dst != '0)),
    .i_set_idx  (w_dst),
    .i_clr      (w_wb_live),
    .i_clr_idx  (wb_waddr),
    .i_fclr     (w_flush_drop),
    .i_fclr_idx (r_ex_dst),
    .i_q_idx    ({w_dst, w_rt, w_rs}),
    .o_q_busy   (w_q_busy),
    .o_busy     (w_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_inst  <= '0;
      r_ex_op1   <= '0;
      r_ex_op2   <= '0;
      r_ex_dst   <= '0;
    end else if (w_fire) begin
      r_ex_valid <= 1'b1;
      r_ex_pc    <= pc;
      r_ex_inst  <= inst;
      r_ex_op1   <= w_op1;
      r_ex_op2   <= w_op2;
      r_ex_dst   <= w_dst;
    end else if (r_ex_valid && (ex_ready || flush)) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_pc    = r_ex_pc;
  assign ex_inst  = r_ex_inst;
  assign ex_op1   = r_ex_op1;
  assign ex_op2   = r_ex_op2;
  assign ex_dst   = r_ex_dst;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed scenarios plus randomized traffic checked against a behavioural
// model of the stage (register file, busy set, one-entry EX slot).
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush, ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_inst, ex_op1, ex_op2;
  logic [4:0]  ex_dst;

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  id_operand_fetch dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_dst(ex_dst)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state
  bit          m_busy [32];
  bit          m_valid;
  logic [31:0] m_pc, m_inst, m_op1, m_op2;
  logic [4:0]  m_dst;

  function automatic logic [4:0] m_dest(input logic [31:0] in);
    logic [5:0] op;
    op = in[31:26];
    if (op == 6'd0) return (in[5:0] == 6'h08) ? 5'd0 : in[15:11];
    if (op == 6'd3) return 5'd31;
    if (op inside {6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7}) return 5'd0;
    if (op >= 6'h28 && op <= 6'h2f) return 5'd0;
    return in[20:16];
  endfunction

  function automatic bit m_blocked(input logic [4:0] r, input logic wen, input logic [4:0] wa);
    return (r != 0) && m_busy[r] && !(wen && wa == r);
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic idle_inputs();
    inst_valid = 0; inst = 0; pc = 0; ex_ready = 1; flush = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst ex_pc", ex_pc, 32'd0);
    check("rst ex_dst", {27'd0, ex_dst}, 32'd0);
    check("rst busy", dut.w_busy, 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst inst_ready", {31'd0, inst_ready}, 32'd1);
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones after posedge.
  task automatic step(input logic v, input logic [31:0] in, input logic exr, input logic fl,
                      input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                      output logic rdy);
    logic [4:0]  rs, rt, d;
    logic        exp_rdy, fire;
    logic [31:0] o1, o2, pcv;
    @(negedge clk);
    pcv = $urandom;
    pc = pcv; inst_valid = v; inst = in; ex_ready = exr; flush = fl;
    wb_wen = wen; wb_waddr = wa; wb_wdata = wd;
    #1;
    rs = in[25:21]; rt = in[20:16]; d = m_dest(in);
    exp_rdy = !fl && !(m_blocked(rs, wen, wa) || m_blocked(rt, wen, wa) || m_blocked(d, wen, wa))
              && (!m_valid || exr);
    check("inst_ready", {31'd0, inst_ready}, {31'd0, exp_rdy});
    check("rf_raddr1", {27'd0, rf_raddr1}, {27'd0, rs});
    check("rf_raddr2", {27'd0, rf_raddr2}, {27'd0, rt});
    rdy  = inst_ready;
    fire = v && exp_rdy;
    o1 = (wen && wa != 0 && wa == rs) ? wd : rf[rs];
    o2 = (wen && wa != 0 && wa == rt) ? wd : rf[rt];
    @(posedge clk);
    #1;
    if (wen && wa != 0) m_busy[wa] = 0;
    if (fl && m_valid && !exr) m_busy[m_dst] = 0;
    if (fire && d != 0) m_busy[d] = 1;
    if (fire) begin
      m_valid = 1; m_pc = pcv; m_inst = in; m_op1 = o1; m_op2 = o2; m_dst = d;
    end else if (m_valid && (exr || fl)) begin
      m_valid = 0;
    end
    if (wen && wa != 0) rf[wa] = wd;
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("ex_pc", ex_pc, m_pc);
      check("ex_inst", ex_inst, m_inst);
      check("ex_op1", ex_op1, m_op1);
      check("ex_op2", ex_op2, m_op2);
      check("ex_dst", {27'd0, ex_dst}, {27'd0, m_dst});
    end
    check("busy", dut.w_busy, m_busy_vec());
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [14];
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    ops = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h02, 6'h04, 6'h05, 6'h06,
            6'h07, 6'h01, 6'h23, 6'h2b, 6'h28, 6'h09};
    op = ops[$urandom_range(0, 13)];
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    if (op == 6'h00)
      return {op, rs, rt, rd, 5'd0, ($urandom_range(0, 4) == 0) ? 6'h08 : 6'h21};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  localparam logic [31:0] I_ADD3 = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] I_ADD4 = {6'd0, 5'd3, 5'd0, 5'd4, 5'd0, 6'h21};
  localparam logic [31:0] I_ADD5 = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h21};
  localparam logic [31:0] I_ADD6 = {6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h21};
  localparam logic [31:0] I_ADD9 = {6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h21};
  localparam logic [31:0] I_LW5  = {6'h23, 5'd1, 5'd5, 16'd0};
  localparam logic [31:0] I_SW6  = {6'h2b, 5'd7, 5'd6, 16'd0};
  localparam logic [31:0] I_JR   = {6'd0, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] I_JAL  = {6'h03, 26'h10};
  localparam logic [31:0] I_ADD8 = {6'd0, 5'd0, 5'd0, 5'd8, 5'd0, 6'h21};

  initial begin
    logic        rdy;
    logic [31:0] held;
    logic [4:0]  cand [$];
    logic [4:0]  wa;
    rst = 1;
    idle_inputs();
    rf[0] = 0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    rf[1] = 5; rf[2] = 7;

    do_reset();

    step(1, I_ADD3, 1, 0, 0, 0, 0, rdy);
    check("t2 op1", ex_op1, 32'd5);
    check("t2 op2", ex_op2, 32'd7);
    check("t2 dst", {27'd0, ex_dst}, 32'd3);
    check("t2 busy3", {31'd0, dut.w_busy[3]}, 32'd1);

    step(1, I_ADD4, 1, 0, 0, 0, 0, rdy);
    check("t3 stall", {31'd0, rdy}, 32'd0);
    step(1, I_ADD4, 1, 0, 1, 5'd3, 32'd12, rdy);
    check("t3 fire", {31'd0, rdy}, 32'd1);
    check("t3 bypass", ex_op1, 32'd12);
    check("t3 busy", dut.w_busy, 32'h0000_0010);

    step(1, I_ADD5, 1, 0, 0, 0, 0, rdy);
    held = ex_inst;
    for (int k = 0; k < 3; k++) begin
      step(1, I_ADD6, 0, 0, 0, 0, 0, rdy);
      check("t4 blocked", {31'd0, rdy}, 32'd0);
      check("t4 held", ex_inst, held);
    end
    step(1, I_ADD6, 1, 0, 0, 0, 0, rdy);
    check("t4 issue", ex_inst, I_ADD6);

    do_reset();
    step(1, I_LW5, 0, 0, 0, 0, 0, rdy);
    check("t5 busy5", {31'd0, dut.w_busy[5]}, 32'd1);
    step(1, I_ADD9, 0, 1, 0, 0, 0, rdy);
    check("t5 flush ready", {31'd0, rdy}, 32'd0);
    check("t5 flush valid", {31'd0, ex_valid}, 32'd0);
    check("t5 flush busy5", {31'd0, dut.w_busy[5]}, 32'd0);

    step(1, I_SW6, 1, 0, 0, 0, 0, rdy);
    check("t6 sw dst", {27'd0, ex_dst}, 32'd0);
    check("t6 sw busy", dut.w_busy, 32'd0);
    step(1, I_JR, 1, 0, 0, 0, 0, rdy);
    check("t6 jr dst", {27'd0, ex_dst}, 32'd0);
    step(1, I_JAL, 1, 0, 0, 0, 0, rdy);
    check("t6 jal dst", {27'd0, ex_dst}, 32'd31);
    check("t6 jal busy31", {31'd0, dut.w_busy[31]}, 32'd1);
    step(1, I_ADD8, 1, 0, 1, 5'd0, 32'd99, rdy);
    check("t6 r0 op1", ex_op1, 32'd0);
    check("t6 r0 busy0", {31'd0, dut.w_busy[0]}, 32'd0);

    do_reset();
    for (int n = 0; n < 500; n++) begin
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) cand.push_back(5'(r));
      if (cand.size() != 0 && $urandom_range(0, 3) != 0)
        wa = cand[$urandom_range(0, cand.size() - 1)];
      else
        wa = 5'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, wa, $urandom, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
